// File: rtl/calc_pkg.sv
// Shared types, sizes and helpers for the BCD calculator sequencing controller.
package calc_pkg;

  localparam int unsigned OPW        = 7;
  localparam int unsigned RESW       = 16;
  localparam int unsigned ITER       = OPW;
  localparam int unsigned CONV_LEN   = 16;
  localparam int unsigned CNT_W      = $clog2(ITER);
  localparam int unsigned CONV_CNT_W = $clog2(CONV_LEN);

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_EXEC = 3'd2,
    S_CONV = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef struct packed {
    logic [3:0] a_tens;
    logic [3:0] a_ones;
    logic [3:0] b_tens;
    logic [3:0] b_ones;
    op_e        op;
  } req_t;

  function automatic logic [OPW-1:0] dec2bin(input logic [3:0] tens, input logic [3:0] ones);
    return OPW'(tens) * OPW'(10) + OPW'(ones);
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [RESW-1:0] dd_step(input logic [RESW-1:0] bcd, input logic bit_in);
    logic [RESW-1:0] adj;
    adj = bcd;
    for (int i = 0; i < int'(RESW / 4); i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return (adj << 1) | RESW'(bit_in);
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_conv.sv
// bcd_seq_conv: sequential double-dabble engine. The load edge performs the first of
// CONV_LEN steps; done_c flags the cycle whose step is the last, with result_c its value.
module bcd_seq_conv
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [RESW-1:0] bin,
  output logic            done_c,
  output logic [RESW-1:0] result_c
);

  logic [RESW-1:0]       bin_q;
  logic [RESW-1:0]       bcd_q;
  logic [CONV_CNT_W-1:0] cnt;
  logic                  run;

  assign result_c = dd_step(bcd_q, bin_q[RESW-1]);
  assign done_c   = run && (cnt == CONV_CNT_W'(CONV_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
      run   <= 1'b0;
    end else if (load) begin
      bcd_q <= dd_step('0, bin[RESW-1]);
      bin_q <= bin << 1;
      cnt   <= CONV_CNT_W'(1);
      run   <= 1'b1;
    end else if (run) begin
      bcd_q <= result_c;
      bin_q <= bin_q << 1;
      cnt   <= cnt + CONV_CNT_W'(1);
      if (done_c) run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the two-operand BCD calculator: capture, validate, execute, convert.
// Optional macro CALC_REMAINDER_EN: DIV reports quotient*100 + remainder instead of the quotient.
module calc_seq_ctrl
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  a_tens,
  input  logic [3:0]  a_ones,
  input  logic [3:0]  b_tens,
  input  logic [3:0]  b_ones,
  input  logic [1:0]  op,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        neg,
  output logic        err_digit,
  output logic        err_div0
);

  state_e            state, state_nxt;
  req_t              req, req_nxt;
  logic [OPW-1:0]    a_val, a_nxt, b_val, b_nxt;
  logic [RESW-1:0]   acc, acc_nxt, sh, sh_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, neg_nxt, err_digit_nxt, err_div0_nxt;
  logic [15:0]       bcd_nxt;

  logic              conv_load, conv_done_c;
  logic [RESW-1:0]   conv_bin, conv_result_c;

  logic              digit_bad, last_iter;
  logic [OPW-1:0]    a_c, b_c, div_q;
  logic [RESW-1:0]   mul_acc, div_result;
  logic [OPW:0]      div_shifted, div_rem;
  logic [OPW+1:0]    div_trial;
  logic              div_qbit;

  assign digit_bad = (req.a_tens > 4'd9) || (req.a_ones > 4'd9) ||
                     (req.b_tens > 4'd9) || (req.b_ones > 4'd9);
  assign a_c       = dec2bin(req.a_tens, req.a_ones);
  assign b_c       = dec2bin(req.b_tens, req.b_ones);
  assign last_iter = (cnt == CNT_W'(ITER - 1));

  // Shift-add multiply: sh holds A shifted left once per iteration, B consumed LSB first.
  assign mul_acc = acc + (b_val[cnt] ? sh : '0);

  // Restoring divide: acc holds the partial remainder, sh[OPW-1:0] the dividend/quotient.
  assign div_shifted = {acc[OPW-1:0], sh[OPW-1]};
  assign div_trial   = {1'b0, div_shifted} - {2'b00, b_val};
  assign div_qbit    = ~div_trial[OPW+1];
  assign div_rem     = div_qbit ? div_trial[OPW:0] : div_shifted;
  assign div_q       = {sh[OPW-2:0], div_qbit};

`ifdef CALC_REMAINDER_EN
  assign div_result = (RESW'(div_q) << 6) + (RESW'(div_q) << 5) + (RESW'(div_q) << 2) +
                      RESW'(div_rem);
`else
  assign div_result = RESW'(div_q);
`endif

  bcd_seq_conv u_conv (
    .clk      (clk),
    .rst      (rst),
    .load     (conv_load),
    .bin      (conv_bin),
    .done_c   (conv_done_c),
    .result_c (conv_result_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      req       <= '0;
      a_val     <= '0;
      b_val     <= '0;
      acc       <= '0;
      sh        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      err_digit <= 1'b0;
      err_div0  <= 1'b0;
    end else begin
      state     <= state_nxt;
      req       <= req_nxt;
      a_val     <= a_nxt;
      b_val     <= b_nxt;
      acc       <= acc_nxt;
      sh        <= sh_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      bcd       <= bcd_nxt;
      neg       <= neg_nxt;
      err_digit <= err_digit_nxt;
      err_div0  <= err_div0_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_nxt       = req;
    a_nxt         = a_val;
    b_nxt         = b_val;
    acc_nxt       = acc;
    sh_nxt        = sh;
    cnt_nxt       = cnt;
    done_nxt      = 1'b0;
    bcd_nxt       = bcd;
    neg_nxt       = neg;
    err_digit_nxt = err_digit;
    err_div0_nxt  = err_div0;
    conv_load     = 1'b0;
    conv_bin      = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          req_nxt   = '{a_tens: a_tens, a_ones: a_ones, b_tens: b_tens, b_ones: b_ones,
                        op: op_e'(op)};
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        neg_nxt       = 1'b0;
        err_digit_nxt = 1'b0;
        err_div0_nxt  = 1'b0;
        a_nxt         = a_c;
        b_nxt         = b_c;
        acc_nxt       = '0;
        sh_nxt        = RESW'(a_c);
        cnt_nxt       = '0;
        if (digit_bad) begin
          err_digit_nxt = 1'b1;
          bcd_nxt       = '0;
          done_nxt      = 1'b1;
          state_nxt     = S_DONE;
        end else if ((req.op == OP_DIV) && (b_c == '0)) begin
          err_div0_nxt  = 1'b1;
          bcd_nxt       = '0;
          done_nxt      = 1'b1;
          state_nxt     = S_DONE;
        end else begin
          state_nxt     = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_nxt = last_iter ? '0 : cnt + CNT_W'(1);
        case (req.op)
          OP_ADD: begin
            conv_bin  = RESW'(a_val) + RESW'(b_val);
            conv_load = 1'b1;
          end
          OP_SUB: begin
            conv_bin  = (a_val >= b_val) ? RESW'(a_val - b_val) : RESW'(b_val - a_val);
            neg_nxt   = (a_val < b_val);
            conv_load = 1'b1;
          end
          OP_MUL: begin
            acc_nxt   = mul_acc;
            sh_nxt    = sh << 1;
            conv_bin  = mul_acc;
            conv_load = last_iter;
          end
          OP_DIV: begin
            acc_nxt   = RESW'(div_rem);
            sh_nxt    = RESW'(div_q);
            conv_bin  = div_result;
            conv_load = last_iter;
          end
        endcase
        if (conv_load) state_nxt = S_CONV;
      end
      S_CONV: begin
        if (conv_done_c) begin
          bcd_nxt   = conv_result_c;
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule
